// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers; one bit per cycle,
// WIDTH iterations plus one sign fix-up cycle, with busy/done handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; MTHI/MTLO complete here in one edge
// MUL    | shift-add iteration, one multiplier bit per cycle
// DIV    | restoring-division iteration, one quotient bit per cycle
// FINISH | sign fix-up, HI/LO written, done pulsed
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FINISH
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   low_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_res_q;
    logic               neg_a_q;
    logic               is_div_q;
    logic               dz_q;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     acc_mul_d;
    logic [WIDTH-1:0]   low_mul_d;

    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH:0]     acc_div_d;
    logic [WIDTH-1:0]   low_div_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fin_d;
    logic [WIDTH-1:0]   lo_fin_d;
    logic               last_iter;

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Signed ops iterate on magnitudes; signs are reapplied in FINISH.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & op1[WIDTH-1];
        b_neg     = op_signed & op2[WIDTH-1];
        a_mag     = a_neg ? -op1 : op1;
        b_mag     = b_neg ? -op2 : op2;
    end

    // {acc, low} shifts right; the add result keeps its carry bit.
    always_comb begin
        mul_sum   = acc_q + (low_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_mul_d = {1'b0, mul_sum[WIDTH:1]};
        low_mul_d = {mul_sum[0], low_q[WIDTH-1:1]};
    end

    // Borrow out of a WIDTH+2 bit subtract decides the quotient bit.
    always_comb begin
        div_shift = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        div_ge    = ~div_diff[WIDTH+1];
        acc_div_d = div_ge ? div_diff[WIDTH:0] : div_shift;
        low_div_d = {low_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod     = {acc_q[WIDTH-1:0], low_q};
        prod_fix = neg_res_q ? -prod : prod;
        quot_fix = neg_res_q ? -low_q : low_q;
        rem_fix  = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (is_div_q) begin
            // With a zero divisor the remainder has absorbed the whole dividend.
            hi_fin_d = rem_fix;
            lo_fin_d = dz_q ? {WIDTH{1'b1}} : quot_fix;
        end else begin
            hi_fin_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_fin_d = prod_fix[WIDTH-1:0];
        end
        last_iter = (cnt_q == CNT_W'(WIDTH-1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state_q   <= S_MUL;
                                busy_q    <= 1'b1;
                                cnt_q     <= '0;
                                acc_q     <= '0;
                                low_q     <= b_mag;
                                mcand_q   <= a_mag;
                                neg_res_q <= a_neg ^ b_neg;
                                neg_a_q   <= a_neg;
                                is_div_q  <= 1'b0;
                                dz_q      <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q   <= S_DIV;
                                busy_q    <= 1'b1;
                                cnt_q     <= '0;
                                acc_q     <= '0;
                                low_q     <= a_mag;
                                mcand_q   <= b_mag;
                                neg_res_q <= a_neg ^ b_neg;
                                neg_a_q   <= a_neg;
                                is_div_q  <= 1'b1;
                                dz_q      <= (op2 == '0);
                            end
                            OP_MTHI: hi_q <= op1;
                            OP_MTLO: lo_q <= op1;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    acc_q <= acc_mul_d;
                    low_q <= low_mul_d;
                    if (last_iter) begin
                        state_q <= S_FINISH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    acc_q <= acc_div_d;
                    low_q <= low_div_d;
                    if (last_iter) begin
                        state_q <= S_FINISH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    hi_q    <= hi_fin_d;
                    lo_q    <= lo_fin_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus random
// mult/div operations checked against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Architectural result of a mult/div, from the instruction-set definition.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sp;
        logic [63:0] p;
        int          sa;
        int          sb;
        eh = '0;
        el = '0;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7, 0))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(20, 0));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op from just after a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int busy_cycles, output bit got_done, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        busy_cycles = 0;
        got_done = 1'b0;
        held = 1'b1;
        op = o;
        op1 = a;
        op2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            op1 = $urandom;
            op2 = $urandom;
            op = 3'($urandom_range(5, 0));
        end
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (hi !== h0 || lo !== l0) held = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = 3'd0;
        op1 = '0;
        op2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++; if ({busy, done, hi, lo} !== 66'd0) $display("FAIL reset_idle cyc%0d: got busy=%b done=%b hi=%h lo=%h expected all zero", c, busy, done, hi, lo); else pass_cnt++;
        end
    endtask

    task automatic test_mult_signed();
        logic [31:0] eh, el;
        int bc; bit gd, hd;
        model(OP_MULT, 32'hFFFF_FFFD, 32'd7, eh, el);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, bc, gd, hd);
        total_cnt++; if (gd !== 1'b1) $display("FAIL mult_done: got %b expected 1", gd); else pass_cnt++;
        total_cnt++; if (bc !== 33) $display("FAIL mult_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
        total_cnt++; if (hd !== 1'b1) $display("FAIL mult_hilo_held: got %b expected 1", hd); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (hi !== eh) $display("FAIL mult_hi: got %h expected %h", hi, eh); else pass_cnt++;
        total_cnt++; if (lo !== el) $display("FAIL mult_lo: got %h expected %h", lo, el); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL mult_done_one_cycle: got %b expected 0", done); else pass_cnt++;
    endtask

    task automatic test_multu_hold();
        logic [31:0] eh, el;
        int bc; bit gd, hd;
        model(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, bc, gd, hd);
        total_cnt++; if (bc !== 33 || gd !== 1'b1) $display("FAIL multu_timing: got busy=%0d done=%b expected 33/1", bc, gd); else pass_cnt++;
        total_cnt++; if (hi !== eh) $display("FAIL multu_hi: got %h expected %h", hi, eh); else pass_cnt++;
        total_cnt++; if (lo !== el) $display("FAIL multu_lo: got %h expected %h", lo, el); else pass_cnt++;
    endtask

    task automatic test_div_cases();
        logic [2:0]  o_t [3] = '{OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] a_t [3] = '{32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] b_t [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] eh, el;
        int bc; bit gd, hd;
        for (int i = 0; i < 3; i++) begin
            model(o_t[i], a_t[i], b_t[i], eh, el);
            run_op(o_t[i], a_t[i], b_t[i], 1'b0, bc, gd, hd);
            total_cnt++; if (bc !== 33 || gd !== 1'b1) $display("FAIL div%0d_timing: got busy=%0d done=%b expected 33/1", i, bc, gd); else pass_cnt++;
            total_cnt++; if (hd !== 1'b1) $display("FAIL div%0d_hilo_held: got %b expected 1", i, hd); else pass_cnt++;
            total_cnt++; if (hi !== eh) $display("FAIL div%0d_hi: got %h expected %h", i, hi, eh); else pass_cnt++;
            total_cnt++; if (lo !== el) $display("FAIL div%0d_lo: got %h expected %h", i, lo, el); else pass_cnt++;
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        op = OP_MTHI; op1 = 32'hA5A5_A5A5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        total_cnt++; if (hi !== 32'hA5A5_A5A5) $display("FAIL mthi_hi: got %h expected a5a5a5a5", hi); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi_busy_done: got %b/%b expected 0/0", busy, done); else pass_cnt++;
        v = $urandom;
        @(negedge clk);
        op = OP_MTLO; op1 = v; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        total_cnt++; if (lo !== v || hi !== 32'hA5A5_A5A5) $display("FAIL mtlo: got hi=%h lo=%h expected a5a5a5a5/%h", hi, lo, v); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo_busy_done: got %b/%b expected 0/0", busy, done); else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a, b, eh, el, h0, l0;
        int bc; bit gd, hd;
        a = $urandom; b = $urandom;
        model(OP_MULT, a, b, eh, el);
        h0 = hi; l0 = lo;
        bc = 0; gd = 1'b0; hd = 1'b1;
        op = OP_MULT; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 100 && !gd; c++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
            else begin
                if (busy) bc++;
                if (hi !== h0 || lo !== l0) hd = 1'b0;
            end
            if (c == 9) begin start = 1'b1; op = OP_MTLO; op1 = 32'hDEAD_BEEF; end
            else if (c == 10) start = 1'b0;
        end
        total_cnt++; if (bc !== 33 || gd !== 1'b1) $display("FAIL busy_start_timing: got busy=%0d done=%b expected 33/1", bc, gd); else pass_cnt++;
        total_cnt++; if (hd !== 1'b1) $display("FAIL busy_start_lo_held: got %b expected 1", hd); else pass_cnt++;
        total_cnt++; if (hi !== eh || lo !== el) $display("FAIL busy_start_result: got %h_%h expected %h_%h", hi, lo, eh, el); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || lo !== el) $display("FAIL busy_start_no_queue: got busy=%b lo=%h expected 0/%h", busy, lo, el); else pass_cnt++;
    endtask

    task automatic test_reserved_op();
        logic [31:0] h0, l0;
        for (int i = 6; i < 8; i++) begin
            h0 = hi; l0 = lo;
            op = 3'(i); op1 = $urandom; op2 = $urandom; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0) $display("FAIL reserved_op%0d: got busy=%b done=%b hi=%h lo=%h expected 0/0/%h/%h", i, busy, done, hi, lo, h0, l0); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, eh, el;
        int bc; bit gd, hd;
        a = $urandom; b = 32'($urandom_range(1000, 1));
        model(OP_DIVU, a, b, eh, el);
        run_op(OP_DIVU, a, b, 1'b0, bc, gd, hd);
        total_cnt++; if (hi !== eh || lo !== el || gd !== 1'b1) $display("FAIL b2b_first: got %h_%h done=%b expected %h_%h/1", hi, lo, gd, eh, el); else pass_cnt++;
        a = $urandom; b = $urandom;
        model(OP_MULT, a, b, eh, el);
        run_op(OP_MULT, a, b, 1'b0, bc, gd, hd);
        total_cnt++; if (bc !== 33 || gd !== 1'b1) $display("FAIL b2b_second_timing: got busy=%0d done=%b expected 33/1", bc, gd); else pass_cnt++;
        total_cnt++; if (hi !== eh || lo !== el) $display("FAIL b2b_second_result: got %h_%h expected %h_%h", hi, lo, eh, el); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, eh, el;
        int bc; bit gd, hd;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(3, 0));
            a = pick_operand();
            b = pick_operand();
            model(o, a, b, eh, el);
            run_op(o, a, b, bit'($urandom_range(1, 0)), bc, gd, hd);
            total_cnt++; if (bc !== 33 || gd !== 1'b1) $display("FAIL rand%0d_timing op=%0d: got busy=%0d done=%b expected 33/1", i, o, bc, gd); else pass_cnt++;
            total_cnt++; if (hd !== 1'b1) $display("FAIL rand%0d_hilo_held op=%0d: got %b expected 1", i, o, hd); else pass_cnt++;
            total_cnt++; if (hi !== eh) $display("FAIL rand%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, eh); else pass_cnt++;
            total_cnt++; if (lo !== el) $display("FAIL rand%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, el); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_op();
        bit saw_busy, saw_done;
        op = OP_MTHI; op1 = 32'h1357_9BDF; start = 1'b1;
        @(posedge clk); #1;
        op = OP_MTLO; op1 = 32'h2468_ACE0;
        @(posedge clk); #1;
        op = OP_MULT; op1 = $urandom; op2 = $urandom;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset_mid_pre_busy: got %b expected 1", busy); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if ({busy, done, hi, lo} !== 66'd0) $display("FAIL reset_mid_clear: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        saw_busy = 1'b0; saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (done) saw_done = 1'b1;
        end
        total_cnt++; if (saw_busy !== 1'b0 || saw_done !== 1'b0) $display("FAIL reset_mid_after: got busy_seen=%b done_seen=%b expected 0/0", saw_busy, saw_done); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_mid_hilo: got %h_%h expected zero", hi, lo); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu_hold();
        test_div_cases();
        test_mthi_mtlo();
        test_start_while_busy();
        test_reserved_op();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
